// File: rtl/rr_grant_encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rr_grant_encoder_pkg
//  Description : Shared constants and FSM state encoding for the 16-way
//                round-robin grant encoder and its pick helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package rr_grant_encoder_pkg;

    // Requester count is fixed by the downstream 4-to-16 decoder.
    localparam int N_REQ    = 16;
    localparam int IDX_W    = 4;
    // Maximum grant hold in cycles; only used when RR_TIMEOUT_EN is defined.
    localparam int MAX_HOLD = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

endpackage : rr_grant_encoder_pkg
`default_nettype wire

// File: rtl/rr_grant_encoder_pick16.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick16
//  Description : Combinational round-robin pick. Rotates the request vector
//                so that bit ptr lands at position 0, finds the lowest set
//                bit, then adds ptr back to recover the absolute index.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick16
    import rr_grant_encoder_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [N_REQ-1:0] w_rot;
    logic [IDX_W-1:0] w_off;

    // Rotate right by ptr; a shift by 16 (ptr==0) yields zero, so the OR is safe.
    assign w_rot = (req >> ptr) | (req << (5'd16 - {1'b0, ptr}));

    // Priority encode: the lowest set bit of the rotated vector wins.
    always_comb begin
        w_off = '0;
        found = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

    // Undo the rotation; 4-bit addition wraps 15 -> 0 naturally.
    assign idx = w_off + ptr;

endmodule : rr_pick16
`default_nettype wire

// File: rtl/rr_grant_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : rr_grant_encoder
//  Description : 16-requester round-robin arbiter producing a registered
//                grant index + valid for a 4-to-16 decoder. An owner keeps
//                the grant until it signals done or drops its request; a
//                one-cycle gap always separates consecutive owners.
//                Optional macro RR_TIMEOUT_EN adds a hold timer that forces
//                release after MAX_HOLD cycles and pulses timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_grant_encoder
    import rr_grant_encoder_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             busy,
    output logic             timeout
);

    state_t           r_state, w_nxt_state;
    logic [IDX_W-1:0] r_ptr, w_nxt_ptr;
    logic [IDX_W-1:0] r_grant_idx, w_nxt_idx;
    logic             r_grant_valid, w_nxt_valid;
    logic             w_nxt_timeout;
    logic             w_release;
    logic             w_timer_hit;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_found;

`ifdef RR_TIMEOUT_EN
    localparam logic [2:0] c_hold_last = 3'(MAX_HOLD - 1);
    logic [2:0] r_hold_cnt, w_nxt_cnt;
    logic       r_timeout;
    assign w_timer_hit = (r_hold_cnt == c_hold_last);
`else
    assign w_timer_hit = 1'b0;
`endif

    rr_pick16 u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .idx   (w_pick_idx),
        .found (w_pick_found)
    );

    assign w_release = done | ~req[r_grant_idx] | w_timer_hit;

    // Next-state and next-output logic for the IDLE/GRANT/GAP arbiter.
    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_idx     = r_grant_idx;
        w_nxt_valid   = 1'b0;
        w_nxt_ptr     = r_ptr;
        w_nxt_timeout = 1'b0;
`ifdef RR_TIMEOUT_EN
        w_nxt_cnt     = r_hold_cnt;
`endif
        case (r_state)
            ST_IDLE, ST_GAP: begin
                // Both are arbitration points; GAP always leaves after one cycle.
                if (w_pick_found) begin
                    w_nxt_state = ST_GRANT;
                    w_nxt_idx   = w_pick_idx;
                    w_nxt_valid = 1'b1;
`ifdef RR_TIMEOUT_EN
                    w_nxt_cnt   = 3'd0;
`endif
                end else begin
                    w_nxt_state = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    w_nxt_state   = ST_GAP;
                    w_nxt_ptr     = r_grant_idx + 4'd1;
                    // Timeout is reported only when the timer alone forced it.
                    w_nxt_timeout = w_timer_hit & ~done;
                end else begin
                    w_nxt_valid = 1'b1;
`ifdef RR_TIMEOUT_EN
                    w_nxt_cnt   = r_hold_cnt + 3'd1;
`endif
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    // State, pointer and registered grant outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_grant_idx   <= '0;
            r_grant_valid <= 1'b0;
        end else begin
            r_state       <= w_nxt_state;
            r_ptr         <= w_nxt_ptr;
            r_grant_idx   <= w_nxt_idx;
            r_grant_valid <= w_nxt_valid;
        end
    end

`ifdef RR_TIMEOUT_EN
    // Hold counter and timeout pulse register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_cnt <= 3'd0;
            r_timeout  <= 1'b0;
        end else begin
            r_hold_cnt <= w_nxt_cnt;
            r_timeout  <= w_nxt_timeout;
        end
    end
    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

    assign grant_idx   = r_grant_idx;
    assign grant_valid = r_grant_valid;
    assign busy        = (r_state != ST_IDLE);

endmodule : rr_grant_encoder
`default_nettype wire

// File: tb/tb_rr_grant_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_grant_encoder
//  Description : Scoreboard bench for rr_grant_encoder with a behavioural
//                4-to-16 decoder on the grant outputs. Stimulus pushes the
//                expected grant sequence; a monitor pops one entry per grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_grant_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] req = 16'h0;
    logic        done = 1'b0;
    logic [3:0]  grant_idx;
    logic        grant_valid;
    logic        busy;
    logic        timeout;
    logic [15:0] y;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] idx;
        int         len;   // expected grant length in cycles, 0 = don't care
        int         gap;   // expected idle cycles before grant, 0 = don't care
        logic       to;    // expected timeout pulse at release
    } exp_t;

    exp_t sb[$];

    rr_grant_encoder dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .busy        (busy),
        .timeout     (timeout)
    );

    // Decoder model standing in for Dec4x16.
    assign y = grant_valid ? (16'h1 << grant_idx) : 16'h0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] idx, input int len, input int gap, input logic to);
        exp_t e;
        e.idx = idx; e.len = len; e.gap = gap; e.to = to;
        sb.push_back(e);
    endtask

    // ---------------- monitor ----------------
    logic prev_valid = 1'b0;
    int   cur_len    = 0;
    int   gap_cnt    = 0;
    exp_t cur;

    always @(negedge clk) begin
        if (grant_valid && !prev_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_grant", {28'h0, grant_idx}, 32'hFFFF_FFFF);
                cur.idx = grant_idx; cur.len = 0; cur.gap = 0; cur.to = 1'b0;
            end else begin
                cur = sb.pop_front();
                chk("grant_idx", {28'h0, grant_idx}, {28'h0, cur.idx});
                chk("decoder_y", {16'h0, y}, {16'h0, 16'h1 << cur.idx});
                if (cur.gap != 0) chk("gap_len", gap_cnt, cur.gap);
            end
            cur_len = 1;
        end else if (grant_valid && prev_valid) begin
            cur_len++;
            if (grant_idx !== cur.idx) chk("owner_stable", {28'h0, grant_idx}, {28'h0, cur.idx});
        end else if (!grant_valid && prev_valid) begin
            if (cur.len != 0) chk("hold_len", cur_len, cur.len);
            chk("timeout_at_release", {31'h0, timeout}, {31'h0, cur.to});
            gap_cnt = 1;
        end else begin
            gap_cnt++;
            if (timeout) chk("stray_timeout", {31'h0, timeout}, 32'h0);
        end
        prev_valid = grant_valid;
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset(input logic [15:0] req_during, input logic [15:0] req_after);
        rst = 1'b1;
        req = req_during;
        done = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid",   {31'h0, grant_valid}, 32'h0);
        chk("rst_idx",     {28'h0, grant_idx},   32'h0);
        chk("rst_busy",    {31'h0, busy},        32'h0);
        chk("rst_timeout", {31'h0, timeout},     32'h0);
        chk("rst_y",       {16'h0, y},           32'h0);
        rst = 1'b0;
        req = req_after;
    endtask

    task automatic wait_valid(input logic want);
        int n = 0;
        while (grant_valid !== want && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (grant_valid !== want) chk("wait_valid_timeout", {31'h0, grant_valid}, {31'h0, want});
    endtask

    // Wait for a live grant, then release it with done for one cycle.
    task automatic serve(input logic [15:0] req_after);
        @(negedge clk);
        wait_valid(1'b1);
        done = 1'b1;
        req = req_after;
        @(negedge clk);
        done = 1'b0;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        // 1: reset with all requests high.
        do_reset(16'hFFFF, 16'h0);

        // 2: single requester, latency 1, release to GAP then IDLE.
        do_reset(16'h0, 16'h0010);
        push(4'd4, 1, 0, 1'b0);
        @(negedge clk);
        chk("t2_latency_valid", {31'h0, grant_valid}, 32'h1);
        chk("t2_latency_idx",   {28'h0, grant_idx},   32'h4);
        done = 1'b1;
        req  = 16'h0;
        @(negedge clk);
        done = 1'b0;
        chk("t2_gap_valid", {31'h0, grant_valid}, 32'h0);
        chk("t2_gap_busy",  {31'h0, busy},        32'h1);
        @(negedge clk);
        chk("t2_idle_busy", {31'h0, busy},        32'h0);

        // 3: two requesters at the ends, pointer wraps 15 -> 0.
        do_reset(16'h0, 16'h8001);
        push(4'd0, 1, 0, 1'b0);
        push(4'd15, 1, 1, 1'b0);
        push(4'd0, 1, 1, 1'b0);
        push(4'd15, 1, 1, 1'b0);
        serve(16'h8001);
        serve(16'h8001);
        serve(16'h8001);
        serve(16'h0);

        // 4: all requesting, full rotation 0..15 then 0.
        do_reset(16'h0, 16'hFFFF);
        for (int i = 0; i < 17; i++) push(4'(i), 1, (i == 0) ? 0 : 1, 1'b0);
        for (int i = 0; i < 16; i++) serve(16'hFFFF);
        serve(16'h0);

        // 5: owner 3 drops its request mid-grant, 7 takes over after a gap.
        do_reset(16'h0, 16'h0088);
        push(4'd3, 3, 0, 1'b0);
        push(4'd7, 1, 1, 1'b0);
        @(negedge clk);
        wait_valid(1'b1);
        repeat (2) @(negedge clk);
        req = 16'h0080;
        serve(16'h0);

        // 6: hold timer behaviour.
`ifdef RR_TIMEOUT_EN
        do_reset(16'h0, 16'h0006);
        push(4'd1, 8, 0, 1'b1);
        push(4'd2, 8, 1, 1'b1);
        push(4'd2, 1, 1, 1'b0);
        begin
            int n = 0;
            while (!(grant_valid && grant_idx == 4'd2) && n < 60) begin
                @(negedge clk);
                n++;
            end
            chk("t6_reach_owner2", {28'h0, grant_idx}, 32'h2);
        end
        req = 16'h0004;
        wait_valid(1'b0);
        serve(16'h0);
`else
        do_reset(16'h0, 16'h0006);
        push(4'd1, 0, 0, 1'b0);
        begin
            int to_seen = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (timeout) to_seen++;
            end
            chk("t6_no_timeout", to_seen, 0);
            chk("t6_still_valid", {31'h0, grant_valid}, 32'h1);
            chk("t6_still_owner", {28'h0, grant_idx},   32'h1);
        end
        do_reset(16'h0, 16'h0);
        @(negedge clk);
        chk("t6_reset_no_timeout", {31'h0, timeout}, 32'h0);
`endif

        // Drain the scoreboard.
        begin
            int n = 0;
            while (sb.size() != 0 && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("scoreboard_empty", sb.size(), 0);
        end
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule : tb_rr_grant_encoder
`default_nettype wire
